// File: rtl/datamem_pkg.sv
// Shared types and helpers for the data memory bank and its clear sequencer.
package datamem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  localparam int BYTE_W = 8;
  // Parity bits stored alongside each byte when parity is built in.
  localparam int PAR_W  = 1;

  function automatic int bytes_per_word(input int data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

// File: rtl/data_memory_bank_if.sv
// CPU-side bus of the data memory bank: request from the data path, read data and status back.
interface data_memory_bank_if
  import datamem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int CPU_ADDR_W = 16
) ();

  localparam int NBYTES = bytes_per_word(DATA_W);

  logic                  write;
  logic [CPU_ADDR_W-1:0] addr;
  logic [DATA_W-1:0]     datain;
  logic [NBYTES-1:0]     byte_en;
  logic [DATA_W-1:0]     dataout;
  logic                  ready;
  logic                  addr_err;
  logic                  parity_err;

  modport master (
    output write, addr, datain, byte_en,
    input  dataout, ready, addr_err, parity_err
  );

  modport slave (
    input  write, addr, datain, byte_en,
    output dataout, ready, addr_err, parity_err
  );

endinterface

// File: rtl/data_memory_clear_seq.sv
// Post-reset clear sequencer: walks every word index once, then holds READY until the next reset.
module data_memory_clear_seq
  import datamem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_idx,
  output logic              ready
);

  clr_state_e        state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  // The last index is written on the same edge that moves the FSM to READY.
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    clr_we      = 1'b0;
    case (state)
      CLEAR: begin
        clr_we      = ~reset;
        clr_ptr_nxt = clr_ptr + 1'b1;
        if (clr_ptr == '1) state_nxt = READY;
      end
      READY:   state_nxt = READY;
      default: state_nxt = CLEAR;
    endcase
  end

  assign clr_idx = clr_ptr;
  assign ready   = (state == READY);

endmodule

// File: rtl/data_memory_bank.sv
// Word-addressed data memory with byte enables, range check and post-reset clear.
// Optional per-byte even parity is built when DATAMEM_PARITY_EN is defined.
module data_memory_bank
  import datamem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int CPU_ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  data_memory_bank_if.slave bus
);

  localparam int NBYTES = bytes_per_word(DATA_W);
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_idx;
  logic              ready;
  logic              in_range;
  logic [ADDR_W-1:0] idx;
  logic              cpu_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_idx;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_word;
  logic              addr_err;

  logic [DATA_W-1:0] mem [DEPTH];

  data_memory_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
    .clk     (clk),
    .reset   (reset),
    .clr_we  (clr_we),
    .clr_idx (clr_idx),
    .ready   (ready)
  );

  assign in_range = (bus.addr[CPU_ADDR_W-1:ADDR_W] == '0);
  assign idx      = bus.addr[ADDR_W-1:0];
  assign cpu_we   = ready & bus.write & in_range;
  assign rd_word  = mem[idx];

  // Sweep and CPU writes never overlap; unselected bytes are merged from the current word.
  always_comb begin
    mem_we    = clr_we | cpu_we;
    mem_idx   = clr_we ? clr_idx : idx;
    mem_wdata = '0;
    if (!clr_we) begin
      for (int i = 0; i < NBYTES; i++) begin
        mem_wdata[BYTE_W*i +: BYTE_W] = bus.byte_en[i] ? bus.datain[BYTE_W*i +: BYTE_W]
                                                       : rd_word[BYTE_W*i +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   addr_err <= 1'b0;
    else if (ready && !in_range) addr_err <= 1'b1;
  end

  assign bus.dataout  = (ready && in_range) ? rd_word : '0;
  assign bus.ready    = ready;
  assign bus.addr_err = addr_err;

`ifdef DATAMEM_PARITY_EN
  logic [NBYTES*PAR_W-1:0] par_mem [DEPTH];
  logic [NBYTES*PAR_W-1:0] par_wdata;
  logic [NBYTES*PAR_W-1:0] rd_par;

  function automatic logic [NBYTES*PAR_W-1:0] byte_parity(input logic [DATA_W-1:0] w);
    logic [NBYTES*PAR_W-1:0] p;
    p = '0;
    for (int i = 0; i < NBYTES; i++) p[i] = ^w[BYTE_W*i +: BYTE_W];
    return p;
  endfunction

  assign rd_par = par_mem[idx];

  always_comb begin
    par_wdata = '0;
    if (!clr_we) begin
      for (int i = 0; i < NBYTES; i++) begin
        par_wdata[i] = bus.byte_en[i] ? ^bus.datain[BYTE_W*i +: BYTE_W] : rd_par[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) par_mem[mem_idx] <= par_wdata;
  end

  assign bus.parity_err = ready & in_range & (|(rd_par ^ byte_parity(rd_word)));
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory_bank.sv
// Directed self-checking bench for data_memory_bank (parity section follows DATAMEM_PARITY_EN).
module tb_data_memory_bank;
  import datamem_pkg::*;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 8;
  localparam int CPU_ADDR_W = 16;
  localparam int DEPTH      = 256;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_memory_bank_if #(.DATA_W(DATA_W), .CPU_ADDR_W(CPU_ADDR_W)) bif ();

  data_memory_bank #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CPU_ADDR_W(CPU_ADDR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] model [DEPTH];

  typedef struct {
    string             tag;
    logic [DATA_W-1:0] exp;
  } sb_t;
  sb_t sb_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] model_read(input logic [CPU_ADDR_W-1:0] a);
    return (a[CPU_ADDR_W-1:ADDR_W] == '0) ? model[a[ADDR_W-1:0]] : '0;
  endfunction

  // Write while ready: new data must not appear before the edge.
  task automatic do_write(input logic [CPU_ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [3:0] be);
    logic [DATA_W-1:0] pre;
    pre = model_read(a);
    bif.write   = 1'b1;
    bif.addr    = a;
    bif.datain  = d;
    bif.byte_en = be;
    #1;
    check($sformatf("no_bypass@%0h", a), bif.dataout, pre);
    if (a[CPU_ADDR_W-1:ADDR_W] == '0)
      for (int i = 0; i < 4; i++)
        if (be[i]) model[a[ADDR_W-1:0]][8*i +: 8] = d[8*i +: 8];
    step();
    bif.write   = 1'b0;
    bif.byte_en = '0;
  endtask

  task automatic do_read(input logic [CPU_ADDR_W-1:0] a, input string tag);
    sb_t e;
    bif.write = 1'b0;
    bif.addr  = a;
    sb_q.push_back('{tag, model_read(a)});
    #1;
    e = sb_q.pop_front();
    check(e.tag, bif.dataout, e.exp);
  endtask

  task automatic sweep(input string tag);
    bit early;
    early = 1'b0;
    for (int n = 1; n <= DEPTH; n++) begin
      step();
      if (n < DEPTH && bif.ready) early = 1'b1;
      if (n == DEPTH - 1) check({tag, "_ready_low_255"}, bif.ready, 1'b0);
      if (n == DEPTH)     check({tag, "_ready_high_256"}, bif.ready, 1'b1);
    end
    check({tag, "_ready_low_whole_sweep"}, early, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit early;
    reset       = 1'b1;
    bif.write   = 1'b0;
    bif.addr    = '0;
    bif.datain  = '0;
    bif.byte_en = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    repeat (2) step();
    for (int i = 0; i < DEPTH; i++) dut.mem[i] = $urandom | 32'h1;
    bif.addr = 16'd9;
    #1;
    check("rst_ready", bif.ready, 1'b0);
    check("rst_addr_err", bif.addr_err, 1'b0);
    check("rst_dataout_forced0", bif.dataout, '0);

    // First sweep, with CPU traffic that must be ignored.
    reset = 1'b0;
    early = 1'b0;
    for (int n = 1; n <= DEPTH; n++) begin
      if (n == 10) begin
        bif.write = 1'b1; bif.addr = 16'd5; bif.datain = 32'hDEADBEEF; bif.byte_en = 4'hF;
      end
      if (n == 13) begin bif.write = 1'b0; bif.addr = 16'h0100; end
      if (n == 16) bif.addr = 16'd200;
      step();
      if (n == 15) check("clear_no_addr_err", bif.addr_err, 1'b0);
      if (n == 16) check("clear_dataout_forced0", bif.dataout, '0);
      if (n < DEPTH && bif.ready) early = 1'b1;
      if (n == DEPTH - 1) check("sweep1_ready_low_255", bif.ready, 1'b0);
      if (n == DEPTH)     check("sweep1_ready_high_256", bif.ready, 1'b1);
    end
    check("sweep1_ready_low_whole_sweep", early, 1'b0);
    check("sweep1_addr_err_clear", bif.addr_err, 1'b0);

    for (int i = 0; i < DEPTH; i++) do_read(CPU_ADDR_W'(i), $sformatf("sweep_zero[%0d]", i));
    do_read(16'd5, "clear_write_dropped");

    // Byte lanes.
    do_write(16'd3, 32'h11223344, 4'hF);
    do_read(16'd3, "full_word_write");
    do_write(16'd3, 32'hAABBCCDD, 4'h5);
    do_read(16'd3, "byte_lane_merge");
    check("byte_lane_const", bif.dataout, 32'h11BB33DD);
    do_write(16'd3, 32'hFFFFFFFF, 4'h0);
    do_read(16'd3, "be_zero_no_change");
    do_write(16'd4, 32'h55AA00FF, 4'hA);
    do_read(16'd4, "be_1010");
    do_write(16'd255, 32'hCAFEF00D, 4'hF);
    do_read(16'd255, "top_word");
    do_read(16'd3, "neighbour_intact");

    // Out-of-range access.
    do_write(16'd0, 32'h12345678, 4'hF);
    check("oor_pre_addr_err", bif.addr_err, 1'b0);
    do_write(16'h0100, 32'hFFFFFFFF, 4'hF);
    check("oor_addr_err_set", bif.addr_err, 1'b1);
    do_read(16'h0100, "oor_dataout_zero");
    do_read(16'd0, "oor_mem0_unchanged");
    do_write(16'h8003, 32'h00000000, 4'hF);
    do_read(16'd3, "oor_high_bit_mem3_unchanged");
    bif.addr = 16'd1;
    repeat (3) step();
    check("addr_err_sticky", bif.addr_err, 1'b1);

    // Reset mid-sweep restarts the clear from index 0.
    reset = 1'b1;
    #1;
    check("rst2_ready_async", bif.ready, 1'b0);
    check("rst2_addr_err_async", bif.addr_err, 1'b0);
    step();
    reset = 1'b0;
    repeat (100) step();
    check("mid_sweep_ready_low", bif.ready, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    sweep("sweep3");
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    do_read(16'd3, "resweep_mem3_zero");
    do_read(16'd0, "resweep_mem0_zero");
    do_read(16'd255, "resweep_mem255_zero");

`ifdef DATAMEM_PARITY_EN
    do_write(16'd7, 32'h000000FF, 4'hF);
    do_read(16'd7, "parity_word");
    check("parity_ok", bif.parity_err, 1'b0);
    dut.par_mem[7][0] = ~dut.par_mem[7][0];
    #1;
    check("parity_flip_detected", bif.parity_err, 1'b1);
`else
    do_write(16'd7, 32'h000000FF, 4'hF);
    do_read(16'd7, "parity_word");
    check("parity_err_tied0", bif.parity_err, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
